// File: rtl/convertidor_bin_bcd_pkg.sv
// Shared types, default sizes and sizing helpers for the binary-to-BCD converter.
// Latency: not applicable (declarations only).
// Backpressure: not applicable (declarations only).
package convertidor_pkg;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        DESPLAZAR = 2'd1,
        FIN       = 2'd2
    } estado_t;

    localparam int ANCHO_BIN_DEF = 16;
    localparam int DIGITOS_DEF   = 5;
    localparam int ANCHO_BCD     = 4 * DIGITOS_DEF;
    localparam int ANCHO_CONT    = $clog2(ANCHO_BIN_DEF + 1);

    // Output word width for a given digit count.
    function automatic int ancho_bcd(input int digitos);
        return 4 * digitos;
    endfunction

    // Iteration counter width; it must be able to hold ANCHO_BIN itself.
    function automatic int ancho_contador(input int ancho_bin);
        return $clog2(ancho_bin + 1);
    endfunction

    // Decimal digits needed to print 2^ancho_bin - 1.
    function automatic int digitos_decimales(input int ancho_bin);
        longint unsigned maximo;
        int n;
        maximo = (64'd1 << ancho_bin) - 64'd1;
        n = 0;
        do begin
            n++;
            maximo = maximo / 64'd10;
        end while (maximo != 64'd0);
        return n;
    endfunction

endpackage

// File: rtl/convertidor_bin_bcd_ajuste.sv
// Add-3 correction for one BCD digit: 5..9 become 8..12, anything lower passes unchanged.
// Latency: combinational.
// Backpressure: none.
module ajuste_bcd (
    input  logic [3:0] digito,
    output logic [3:0] corregido
);

    assign corregido = (digito >= 4'd5) ? (digito + 4'd3) : digito;

endmodule

// File: rtl/convertidor_bin_bcd.sv
// Sequential binary-to-BCD converter (double dabble) with a hex pass-through mode.
// Latency: ANCHO_BIN+1 edges from the start edge in decimal mode, 1 edge in hex mode.
// Backpressure: inicio is ignored while ocupado is high; nothing is queued.
module convertidor_bin_bcd
    import convertidor_pkg::*;
#(
    parameter int ANCHO_BIN = 16,
    parameter int DIGITOS   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inicio,
    input  logic                   modo_hex,
    input  logic [ANCHO_BIN-1:0]   binario,
    output logic [4*DIGITOS-1:0]   codigo_BCD,
    output logic                   ocupado,
    output logic                   listo
);

    localparam int W_BCD  = ancho_bcd(DIGITOS);
    localparam int W_CONT = ancho_contador(ANCHO_BIN);

    // Too few digits would let a digit exceed 9 before correction and corrupt the result.
    if ((DIGITOS < digitos_decimales(ANCHO_BIN)) || (4 * DIGITOS < ANCHO_BIN)) begin : g_param_invalido
        $error("convertidor_bin_bcd: DIGITOS too small for ANCHO_BIN");
    end

    estado_t              estado;
    logic [ANCHO_BIN-1:0] operando;
    logic [W_BCD-1:0]     scratch;
    logic [W_BCD-1:0]     corregido;
    logic [W_CONT-1:0]    contador;
    logic                 modo;

    // One add-3 corrector per digit, all applied in parallel before each shift.
    for (genvar i = 0; i < DIGITOS; i++) begin : g_ajuste
        ajuste_bcd u_ajuste (
            .digito    (scratch[4*i +: 4]),
            .corregido (corregido[4*i +: 4])
        );
    end

    // Control FSM, shift datapath and registered outputs; codigo_BCD only moves in FIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado     <= REPOSO;
            operando   <= '0;
            scratch    <= '0;
            contador   <= '0;
            modo       <= 1'b0;
            codigo_BCD <= '0;
            ocupado    <= 1'b0;
            listo      <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (inicio) begin
                        operando <= binario;
                        modo     <= modo_hex;
                        scratch  <= '0;
                        contador <= '0;
                        ocupado  <= 1'b1;
                        estado   <= modo_hex ? FIN : DESPLAZAR;
                    end
                end
                DESPLAZAR: begin
                    scratch  <= {corregido[W_BCD-2:0], operando[ANCHO_BIN-1]};
                    operando <= {operando[ANCHO_BIN-2:0], 1'b0};
                    contador <= contador + W_CONT'(1);
                    if (contador == W_CONT'(ANCHO_BIN - 1)) begin
                        estado <= FIN;
                    end
                end
                FIN: begin
                    codigo_BCD <= modo ? W_BCD'(operando) : scratch;
                    listo      <= 1'b1;
                    ocupado    <= 1'b0;
                    estado     <= REPOSO;
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_convertidor_bin_bcd.sv
// Self-checking bench for convertidor_bin_bcd: scoreboard of expected results, latency and stability checks.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_convertidor_bin_bcd;

    logic        clk;
    logic        reset;
    logic        inicio;
    logic        modo_hex;
    logic [15:0] binario;
    logic [19:0] codigo_BCD;
    logic        ocupado;
    logic        listo;

    int n_comp   = 0;
    int n_fallos = 0;
    int n_listo  = 0;
    int ciclo    = 0;

    logic [19:0] esperados[$];
    logic [19:0] ultimo = '0;

    convertidor_bin_bcd #(.ANCHO_BIN(16), .DIGITOS(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .inicio     (inicio),
        .modo_hex   (modo_hex),
        .binario    (binario),
        .codigo_BCD (codigo_BCD),
        .ocupado    (ocupado),
        .listo      (listo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ciclo++;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_fallos++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, esp, ciclo);
        end
    endtask

    // Reference: decimal digits by repeated division, or plain zero-extension in hex mode.
    function automatic logic [19:0] modelo(input logic [15:0] b, input bit h);
        logic [19:0] r;
        int v;
        if (h) return {4'h0, b};
        r = '0;
        v = int'(b);
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Output monitor: scores every listo pulse and checks codigo_BCD holds between pulses.
    always @(negedge clk) begin
        if (!reset) begin
            ultimo = '0;
        end else if (listo) begin
            n_listo++;
            if (esperados.size() == 0) begin
                comprobar("listo_inesperado", 32'd1, 32'd0);
            end else begin
                comprobar("codigo", 32'(codigo_BCD), 32'(esperados.pop_front()));
            end
            ultimo = codigo_BCD;
        end else begin
            comprobar("estable", 32'(codigo_BCD), 32'(ultimo));
        end
    end

    // Drive one start; returns at the negedge right after the sampling edge.
    task automatic iniciar(input logic [15:0] b, input bit h);
        @(negedge clk);
        esperados.push_back(modelo(b, h));
        inicio   = 1'b1;
        binario  = b;
        modo_hex = h;
        @(negedge clk);
        inicio = 1'b0;
    endtask

    // Count negedges until listo, with a bound; also counts cycles with ocupado high.
    task automatic esperar_pulso(output int n, output int n_ocup);
        n = 0;
        n_ocup = ocupado ? 1 : 0;
        do begin
            @(negedge clk);
            n++;
            if (ocupado) n_ocup++;
        end while (!listo && n < 100);
        if (!listo) comprobar("timeout", 32'd0, 32'd1);
    endtask

    task automatic convertir(input logic [15:0] b, input bit h, input int lat);
        int n;
        int n_ocup;
        iniciar(b, h);
        comprobar("ocupado_tras_inicio", 32'(ocupado), 32'd1);
        esperar_pulso(n, n_ocup);
        comprobar("latencia", 32'(n), 32'(lat));
        comprobar("ciclos_ocupado", 32'(n_ocup), 32'(lat));
        @(negedge clk);
        comprobar("listo_un_ciclo", 32'(listo), 32'd0);
    endtask

    initial begin
        int n;
        int n_ocup;
        int cuenta;

        reset    = 1'b0;
        inicio   = 1'b0;
        modo_hex = 1'b0;
        binario  = '0;
        #1;
        comprobar("reset_codigo", 32'(codigo_BCD), 32'd0);
        comprobar("reset_ocupado", 32'(ocupado), 32'd0);
        comprobar("reset_listo", 32'(listo), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Decimal conversions, including zero and full scale.
        convertir(16'd0, 1'b0, 17);
        convertir(16'd65535, 1'b0, 17);
        convertir(16'd1234, 1'b0, 17);
        convertir(16'd9999, 1'b0, 17);

        // Hex pass-through.
        convertir(16'hABCD, 1'b1, 1);
        convertir(16'd1234, 1'b0, 17);

        // A start while busy must be ignored.
        cuenta = n_listo;
        iniciar(16'd4321, 1'b0);
        repeat (4) @(negedge clk);
        inicio  = 1'b1;
        binario = 16'd7;
        repeat (3) @(negedge clk);
        inicio = 1'b0;
        esperar_pulso(n, n_ocup);
        repeat (25) @(negedge clk);
        comprobar("pulsos_con_inicio_ignorado", 32'(n_listo - cuenta), 32'd1);

        // Reset in the middle of a conversion aborts it with no listo pulse.
        cuenta = n_listo;
        iniciar(16'd500, 1'b0);
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        comprobar("abort_codigo", 32'(codigo_BCD), 32'd0);
        comprobar("abort_ocupado", 32'(ocupado), 32'd0);
        comprobar("abort_listo", 32'(listo), 32'd0);
        esperados.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        comprobar("pulsos_tras_abort", 32'(n_listo - cuenta), 32'd0);
        convertir(16'd42, 1'b0, 17);

        // inicio held high: one result every 18 cycles, output steady between pulses.
        @(negedge clk);
        for (int i = 0; i < 4; i++) esperados.push_back(modelo(16'd99, 1'b0));
        inicio   = 1'b1;
        binario  = 16'd99;
        modo_hex = 1'b0;
        esperar_pulso(n, n_ocup);
        for (int i = 0; i < 3; i++) begin
            esperar_pulso(n, n_ocup);
            comprobar("periodo_continuo", 32'(n), 32'd18);
        end
        inicio = 1'b0;
        repeat (25) @(negedge clk);
        comprobar("cola_vacia", 32'(esperados.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_comp, n_fallos);
        $finish;
    end

endmodule

// File: doc/convertidor_bin_bcd.md
Name: convertidor_bin_bcd

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the 7-segment display driver and produces the packed-nibble `codigo_BCD` word that the driver multiplexes onto the digits. A hex mode bypasses conversion, so the same driver can show the operand in hexadecimal. It uses a start/busy/done handshake, and the output register holds the last result between conversions.

Parameters:
- ANCHO_BIN, 16, width of the binary operand in bits.
- DIGITOS, 5, number of output digits (4 bits each). Must satisfy DIGITOS >= decimal digit count of 2^ANCHO_BIN-1, and 4*DIGITOS >= ANCHO_BIN. Elaboration-time check fails otherwise.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset; forces the reset state immediately while low.
- inicio  in  1  start request; sampled only in REPOSO.
- modo_hex  in  1  1 = pass binary through as hex nibbles; 0 = decimal conversion. Sampled with inicio.
- binario  in  ANCHO_BIN  operand; sampled with inicio.
- codigo_BCD  out  4*DIGITOS  result; digit 0 (units) in [3:0], digit i in [4i+3:4i]. Feeds the display driver.
- ocupado  out  1  high while a conversion is in progress.
- listo  out  1  one-cycle pulse; high in the cycle codigo_BCD shows a new result.

Behaviour:
- Reset (reset=0, asynchronous): state REPOSO; codigo_BCD=0; listo=0; ocupado=0; the operand shift register, BCD scratch register and iteration counter are all cleared.
- States:
  - REPOSO, DESPLAZAR and FIN; all outputs are registered.
- REPOSO:
  - If inicio=1 at edge k: latch binario and modo_hex; clear scratch; counter=0; ocupado=1 after edge k.
  - Next state is DESPLAZAR if modo_hex=0, otherwise FIN.
  - If inicio=0, stay in REPOSO.
- DESPLAZAR, one iteration per edge:
  - Every scratch digit >= 5 gets +3.
  - Then {scratch, operand} shifts left by 1, with the operand MSB entering scratch bit 0.
  - Counter increments.
  - After ANCHO_BIN iterations (edges k+1..k+ANCHO_BIN), go to FIN.
- FIN, one edge:
  - codigo_BCD <= scratch in decimal mode; in hex mode, the operand zero-extended to 4*DIGITOS bits.
  - listo=1 for exactly that cycle; ocupado=0; next state REPOSO.
- Latency from the inicio-sampling edge k to the edge that updates codigo_BCD and raises listo:
  - Decimal: ANCHO_BIN+1 edges (17 at default).
  - Hex: 1 edge.
- Throughput with inicio held high: one conversion every ANCHO_BIN+2 cycles in decimal mode (18 at default), every 2 cycles in hex mode. FIN always returns to REPOSO before a new start is accepted.
- inicio asserted while ocupado=1 is ignored; it is not queued.
- Changes on binario or modo_hex while ocupado=1 have no effect.
- codigo_BCD is stable except in the FIN update cycle, so the display never sees intermediate scratch values.
- Add-3 correction: a 4-bit digit in 5..9 maps to 8..12. Digits never exceed 9 before correction given the DIGITOS constraint.
- Reset asserted mid-conversion: abort immediately; outputs return to reset values; no listo pulse.

Decomposition:
- Package convertidor_pkg:
  - State enum estado_t {REPOSO, DESPLAZAR, FIN}.
  - Constants: ANCHO_BCD = 4*DIGITOS, and the counter width $clog2(ANCHO_BIN+1).
- One combinational sub-module, ajuste_bcd: takes a 4-bit digit and returns the digit +3 when it is >= 5, else unchanged. Instantiated DIGITOS times through generate.
- The FSM, counter and registers live in the top module.

Test Plan:
- binario=0, decimal, pulse inicio → listo exactly 17 cycles later; codigo_BCD=20'h00000; ocupado high 17 cycles.
- binario=65535, decimal → codigo_BCD=20'h65535. binario=1234 → 20'h01234. binario=9999 → 20'h09999.
- binario=16'hABCD, modo_hex=1 → listo 1 cycle after start; codigo_BCD=20'h0ABCD.
- Start with 4321; at cycle 5 raise inicio with binario=7 → second start ignored; result 20'h04321; only one listo pulse.
- Start with 500; drop reset low at cycle 8 → codigo_BCD=0, ocupado=0, listo never pulses. Release reset, convert 42 → 20'h00042.
- Hold inicio=1 with binario=99 → listo pulses every 18 cycles; codigo_BCD stays 20'h00099 and never shows intermediate values between pulses.
